col_feeder55_16: RTL and testbench
==================================

# col_feeder55_16

Column feeder for the 16-channel 5x5 convolution stage. It accepts one 16-channel feature-map frame as a raster pixel stream and stores it. It then replays the frame as vertical 5-pixel columns in1..in5 with an `en` strobe, which is the input side the 16-channel 5x5 convolver consumes. It also flags the beats on which a full 5x5 window has been delivered, so downstream logic knows when `convValue` is meaningful.

## Interface
- BIT_WIDTH, 8, bits per channel sample
- IMG_W, 5, frame width in pixels (>= 5)
- IMG_H, 5, frame height in pixels (>= 5)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- s_valid  in  1  input pixel valid
- s_ready  out  1  feeder accepts a pixel
- s_data  in  16*BIT_WIDTH  one pixel; channel i at bits [BIT_WIDTH*(i+1)-1 : BIT_WIDTH*i]
- stall  in  1  downstream hold request; freezes streaming
- en  out  1  column beat strobe, drives the convolver enable
- in1..in5  out  16*BIT_WIDTH each  column pixels, rows r..r+4 top to bottom, same channel packing as s_data
- win_valid  out  1  this beat completes a 5x5 window
- win_row  out  $clog2(IMG_H)  window top row (valid with win_valid)
- win_col  out  $clog2(IMG_W)  window left column (valid with win_valid)
- frame_done  out  1  one-cycle pulse after the last beat of a frame

## Operation
- States: LOAD, STREAM.
- **LOAD**
  - s_ready=1.
  - Each s_valid&&s_ready stores s_data at raster address y*IMG_W+x and advances x, then y.
  - Acceptance of pixel IMG_W*IMG_H-1 moves to STREAM and drops s_ready on the next cycle.
- **STREAM**
  - s_ready=0.
  - Counters r in 0..IMG_H-5 and c in 0..IMG_W-1, starting at (0,0).
  - Each non-stalled cycle emits one beat: en=1, inK = pixel (r+K-1, c), then c increments.
  - When c wraps from IMG_W-1 to 0, r increments.
  - A beat with c >= 4 sets win_valid=1, win_row=r, win_col=c-4. Otherwise win_valid=0.
  - Beats per frame = (IMG_H-4)*IMG_W. Windows per frame = (IMG_H-4)*(IMG_W-4).
  - After the final beat (r=IMG_H-5, c=IMG_W-1): pulse frame_done, return to LOAD, zero all counters.
- **stall**
  - While stall=1 in STREAM: en=0, win_valid=0, counters hold.
  - in1..in5 hold their last value.
  - stall is ignored in LOAD.
- Column values are raw stored samples. The feeder performs no arithmetic.
- A frame is never overwritten while streaming, because s_ready=0 in STREAM.

## Timing
- All outputs are registered.
- **Reset values:** s_ready=0, en=0, in1..in5=0, win_valid=0, win_row=0, win_col=0, frame_done=0, state=LOAD, all counters 0.
- s_ready rises the first cycle after rst deasserts.
- **Latency:** with the last pixel accepted at cycle T, the first beat (en=1) appears at T+2. Unstalled beats are back-to-back.
- frame_done pulses the cycle after the final beat. s_ready=1 in that same cycle.
- A stall sampled high at cycle t suppresses the beat registered at t+1. Deasserting stall resumes at the held (r,c) with no lost or repeated beat.
- rst mid-LOAD or mid-STREAM discards the frame and all counters. The next cycle matches the post-reset state, and no frame_done is issued.
- s_valid is ignored while s_ready=0. s_data needs no stability in that case.

## Structure
- Shared package `lenet_pkg`:
  - K=5 (kernel size)
  - CH=16 (channel count)
  - state enum {LOAD, STREAM}
  - pixel width function CH*BIT_WIDTH
- Sub-module `fmap_store`:
  - IMG_W*IMG_H x (16*BIT_WIDTH) register array.
  - One synchronous write port.
  - Five combinational read ports addressed (r+k)*IMG_W+c.
  - The top level registers its outputs into in1..in5.
- The top holds the FSM, the write counters (x,y), the read counters (r,c), and the output registers.

## Test plan
- **5x5 frame, pixel n = all channels = n (0..24):** 5 beats starting T+2. Beat c gives in1..in5 = c, 5+c, 10+c, 15+c, 20+c. win_valid only on beat 4, with (0,0). frame_done at T+7.
- **IMG_W=IMG_H=7, ramp data:** 21 beats, 9 win_valid pulses. (win_row,win_col) runs (0,0),(0,1),(0,2),(1,0)..(2,2). On the beat for window (1,2), in3 = pixel (3,6).
- **7x7, stall high for 3 cycles mid-row at c=3:** en low for exactly 3 cycles. The beat sequence is identical to the unstalled run, with no duplicates or gaps.
- **rst asserted during beat 2 of a 5x5 stream:** next cycle all outputs are at reset values and there is no frame_done. A fresh 25-pixel load then streams correctly.
- **Back-to-back frames with s_valid held high:** no pixel accepted during STREAM. The second frame loads starting at the frame_done cycle and its beats carry the second frame's data.
- **Channel packing, pixel with channel i = i+1 (BIT_WIDTH=8):** in1 byte i equals i+1 for all 16 channels. Negative sample 0x80 passes unchanged.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline definitions: kernel size, channel count, FSM states.
package lenet_pkg;

  localparam int unsigned K  = 5;
  localparam int unsigned CH = 16;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int unsigned pix_w(input int unsigned bw);
    return CH * bw;
  endfunction

endpackage

// File: rtl/col_feeder55_16_store.sv
// Frame buffer: one synchronous raster write port, five combinational column reads.
module fmap_store
  import lenet_pkg::*;
#(
  parameter  int unsigned PW    = 128,
  parameter  int unsigned IMG_W = 5,
  parameter  int unsigned IMG_H = 5,
  localparam int unsigned AW    = $clog2(IMG_W * IMG_H),
  localparam int unsigned RW    = $clog2(IMG_H),
  localparam int unsigned CW    = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic [PW-1:0] rdata [K]
);

  localparam int unsigned DEPTH = IMG_W * IMG_H;

  logic [PW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Port k reads row (row+k) of the current column.
  always_comb begin
    for (int unsigned k = 0; k < K; k++) begin
      rdata[k] = mem[AW'((32'(row) + k) * IMG_W + 32'(col))];
    end
  end

endmodule

// File: rtl/col_feeder55_16.sv
// Column feeder for the 16-channel 5x5 convolver: loads one raster frame,
// then replays it as vertical 5-pixel columns with window tracking.
module col_feeder55_16
  import lenet_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned IMG_W     = 5,
  parameter int unsigned IMG_H     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [pix_w(BIT_WIDTH)-1:0]   s_data,
  input  logic                          stall,
  output logic                          en,
  output logic [pix_w(BIT_WIDTH)-1:0]   in1,
  output logic [pix_w(BIT_WIDTH)-1:0]   in2,
  output logic [pix_w(BIT_WIDTH)-1:0]   in3,
  output logic [pix_w(BIT_WIDTH)-1:0]   in4,
  output logic [pix_w(BIT_WIDTH)-1:0]   in5,
  output logic                          win_valid,
  output logic [$clog2(IMG_H)-1:0]      win_row,
  output logic [$clog2(IMG_W)-1:0]      win_col,
  output logic                          frame_done
);

  localparam int unsigned PW = pix_w(BIT_WIDTH);
  localparam int unsigned AW = $clog2(IMG_W * IMG_H);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, c_q, c_d;
  logic [RW-1:0] y_q, y_d, r_q, r_d;
  logic          rdy_d, en_d, wv_d, fin_q, fin_d;
  logic [RW-1:0] wr_d;
  logic [CW-1:0] wc_d;
  logic [PW-1:0] col_q [K];
  logic [PW-1:0] col_d [K];
  logic [PW-1:0] rd    [K];
  logic          accept;
  logic [AW-1:0] waddr;

  assign accept = s_ready & s_valid;
  assign waddr  = AW'(32'(y_q) * IMG_W + 32'(x_q));

  fmap_store #(
    .PW    (PW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_store (
    .clk   (clk),
    .we    (accept),
    .waddr (waddr),
    .wdata (s_data),
    .row   (r_q),
    .col   (c_q),
    .rdata (rd)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    c_d     = c_q;
    rdy_d   = 1'b0;
    en_d    = 1'b0;
    wv_d    = 1'b0;
    wr_d    = win_row;
    wc_d    = win_col;
    col_d   = col_q;
    fin_d   = 1'b0;
    case (state_q)
      LOAD: begin
        rdy_d = 1'b1;
        if (accept) begin
          if (x_q == CW'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q == RW'(IMG_H - 1)) begin
              y_d     = '0;
              state_d = STREAM;
              rdy_d   = 1'b0;
            end else begin
              y_d = y_q + RW'(1);
            end
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (!stall) begin
          en_d  = 1'b1;
          col_d = rd;
          if (c_q >= CW'(K - 1)) begin
            wv_d = 1'b1;
            wr_d = r_q;
            wc_d = c_q - CW'(K - 1);
          end
          if (c_q == CW'(IMG_W - 1)) begin
            c_d = '0;
            if (r_q == RW'(IMG_H - K)) begin
              // Final beat: s_ready stays low one more cycle so it rises with frame_done.
              r_d     = '0;
              state_d = LOAD;
              fin_d   = 1'b1;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      s_ready    <= 1'b0;
      en         <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      fin_q      <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned k = 0; k < K; k++) begin
        col_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      r_q        <= r_d;
      c_q        <= c_d;
      s_ready    <= rdy_d;
      en         <= en_d;
      win_valid  <= wv_d;
      win_row    <= wr_d;
      win_col    <= wc_d;
      fin_q      <= fin_d;
      frame_done <= fin_q;
      col_q      <= col_d;
    end
  end

  assign in1 = col_q[0];
  assign in2 = col_q[1];
  assign in3 = col_q[2];
  assign in4 = col_q[3];
  assign in5 = col_q[4];

endmodule

// File: tb/tb_col_feeder55_16.sv
// Directed bench for col_feeder55_16: 5x5 and 7x7 instances, hand-derived expectations.
module tb_col_feeder55_16;

  localparam int unsigned PW = 128;
  localparam logic [PW-1:0] PACK = 128'h100f0e0d0c0b0a090807060504030201;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s_valid, stall, sel7;
  logic [PW-1:0] s_data;

  logic          s_valid5, s_ready5, en5, wv5, done5;
  logic          s_valid7, s_ready7, en7, wv7, done7;
  logic [2:0]    wr5, wc5, wr7, wc7;
  logic [PW-1:0] i5 [5];
  logic [PW-1:0] i7 [5];

  logic          o_rdy, o_en, o_wv, o_done;
  logic [2:0]    o_wr, o_wc;
  logic [PW-1:0] o_in [5];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  assign s_valid5 = s_valid & ~sel7;
  assign s_valid7 = s_valid & sel7;

  col_feeder55_16 #(.BIT_WIDTH(8), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .rst(rst), .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data),
    .stall(stall), .en(en5), .in1(i5[0]), .in2(i5[1]), .in3(i5[2]), .in4(i5[3]),
    .in5(i5[4]), .win_valid(wv5), .win_row(wr5), .win_col(wc5), .frame_done(done5)
  );

  col_feeder55_16 #(.BIT_WIDTH(8), .IMG_W(7), .IMG_H(7)) u7 (
    .clk(clk), .rst(rst), .s_valid(s_valid7), .s_ready(s_ready7), .s_data(s_data),
    .stall(stall), .en(en7), .in1(i7[0]), .in2(i7[1]), .in3(i7[2]), .in4(i7[3]),
    .in5(i7[4]), .win_valid(wv7), .win_row(wr7), .win_col(wc7), .frame_done(done7)
  );

  always_comb begin
    o_rdy  = sel7 ? s_ready7 : s_ready5;
    o_en   = sel7 ? en7      : en5;
    o_wv   = sel7 ? wv7      : wv5;
    o_wr   = sel7 ? wr7      : wr5;
    o_wc   = sel7 ? wc7      : wc5;
    o_done = sel7 ? done7    : done5;
    for (int q = 0; q < 5; q++) o_in[q] = sel7 ? i7[q] : i5[q];
  end

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ramp n, mode 1: ramp n+100, mode 2: ramp with packing/0x80 probes
  function automatic logic [PW-1:0] pix(input int unsigned mode, input int unsigned n,
                                        input int unsigned w);
    logic [7:0] v;
    v   = (mode == 1) ? 8'(n + 100) : 8'(n);
    pix = {16{v}};
    if (mode == 2 && n == 0) pix = PACK;
    if (mode == 2 && n == w) pix = {16{8'h80}};
  endfunction

  task automatic load(input int unsigned w, input int unsigned h, input int unsigned mode,
                      input bit keep);
    int unsigned t;
    t = 0;
    while (!o_rdy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("load_ready", PW'(o_rdy), PW'(1));
    for (int unsigned n = 0; n < w * h; n++) begin
      s_valid = 1'b1;
      s_data  = pix(mode, n, w);
      @(posedge clk); #1;
    end
    s_valid = keep;
    s_data  = {16{8'hee}};
  endtask

  task automatic collect(input int unsigned w, input int unsigned h, input int unsigned mode,
                         input int unsigned stall_at, input int unsigned stall_len);
    int unsigned b, wins, gaps, rem, first, last, dcyc, r, c;
    bit stalled;
    b = 0; wins = 0; gaps = 0; rem = 0; first = 0; last = 0; dcyc = 0; stalled = 0;
    for (int unsigned k = 1; k <= (h - 4) * w + stall_len + 10 && dcyc == 0; k++) begin
      @(negedge clk);
      if (rem > 0) begin
        rem--;
        if (rem == 0) stall = 1'b0;
      end
      if (o_en) begin
        if (b == 0) first = k;
        last = k;
        r = b / w;
        c = b % w;
        for (int unsigned q = 0; q < 5; q++)
          chk($sformatf("in%0d_b%0d", q + 1, b), o_in[q], pix(mode, (r + q) * w + c, w));
        chk($sformatf("wv_b%0d", b), PW'(o_wv), PW'(c >= 4));
        if (c >= 4) begin
          chk($sformatf("wrow_b%0d", b), PW'(o_wr), PW'(r));
          chk($sformatf("wcol_b%0d", b), PW'(o_wc), PW'(c - 4));
        end
        if (o_wv) wins++;
        if (mode == 0 && w == 7 && o_wv && o_wr == 3'd1 && o_wc == 3'd2)
          chk("in3_win12", o_in[2], {16{8'd27}});
        if (mode == 2 && b == 0) begin
          chk("pack_in1", o_in[0], PACK);
          chk("pack_in2_0x80", o_in[1], {16{8'h80}});
        end
        if (stall_len > 0 && b == stall_at && !stalled) begin
          stall   = 1'b1;
          rem     = stall_len;
          stalled = 1'b1;
        end
        b++;
      end else if (b > 0 && !o_done) begin
        gaps++;
      end
      if (o_done) begin
        dcyc = k;
        chk("done_ready", PW'(o_rdy), PW'(1));
      end
    end
    chk("done_seen", PW'(dcyc != 0), PW'(1));
    chk("beats", PW'(b), PW'((h - 4) * w));
    chk("wins", PW'(wins), PW'((h - 4) * (w - 4)));
    chk("first_beat", PW'(first), PW'(2));
    chk("done_cycle", PW'(dcyc), PW'(last + 1));
    chk("stall_gap", PW'(gaps), PW'(stall_len));
  endtask

  initial begin
    int unsigned nb, ndone;
    bit hit;
    rst = 1'b1; s_valid = 1'b0; stall = 1'b0; sel7 = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", PW'(o_rdy), PW'(0));
    chk("rst_en", PW'(o_en), PW'(0));
    chk("rst_in1", o_in[0], '0);
    chk("rst_in5", o_in[4], '0);
    chk("rst_wv", PW'(o_wv), PW'(0));
    chk("rst_wrow", PW'(o_wr), PW'(0));
    chk("rst_wcol", PW'(o_wc), PW'(0));
    chk("rst_done", PW'(o_done), PW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", PW'(o_rdy), PW'(1));

    load(5, 5, 0, 1'b0);
    collect(5, 5, 0, 0, 0);

    load(5, 5, 2, 1'b0);
    collect(5, 5, 2, 0, 0);

    load(5, 5, 0, 1'b0);
    nb = 0; hit = 0;
    for (int unsigned k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      if (o_en) begin
        nb++;
        if (nb == 3) begin
          rst = 1'b1;
          hit = 1'b1;
        end
      end
    end
    chk("rst_beat_seen", PW'(hit), PW'(1));
    @(negedge clk);
    chk("mid_rst_ready", PW'(o_rdy), PW'(0));
    chk("mid_rst_en", PW'(o_en), PW'(0));
    for (int q = 0; q < 5; q++) chk($sformatf("mid_rst_in%0d", q + 1), o_in[q], '0);
    chk("mid_rst_wv", PW'(o_wv), PW'(0));
    chk("mid_rst_wrow", PW'(o_wr), PW'(0));
    chk("mid_rst_wcol", PW'(o_wc), PW'(0));
    chk("mid_rst_done", PW'(o_done), PW'(0));
    rst = 1'b0;
    ndone = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("mid_rst_no_done", PW'(ndone), PW'(0));
    chk("mid_rst_ready_back", PW'(o_rdy), PW'(1));
    load(5, 5, 0, 1'b0);
    collect(5, 5, 0, 0, 0);

    load(5, 5, 0, 1'b1);
    collect(5, 5, 0, 0, 0);
    load(5, 5, 1, 1'b0);
    collect(5, 5, 1, 0, 0);

    sel7 = 1'b1;
    load(7, 7, 0, 1'b0);
    collect(7, 7, 0, 0, 0);
    load(7, 7, 0, 1'b0);
    collect(7, 7, 0, 3, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
